joy_serializer: RTL

JOY_SERIALIZER -- requirements
Module: joy_serializer

---
 rtl/joy_pkg.sv | 29 ++
 rtl/sync_edge.sv | 35 +++
 rtl/joy_serializer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/joy_pkg.sv
// Shared constants, state encoding and frame-image helper for the joystick serializer.
package joy_pkg;

  localparam int FRAME_BITS_DEFAULT = 16;

  // Button bit positions inside joy1_i / joy2_i (buttons are active-low)
  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_FIRE1 = 4;
  localparam int BTN_FIRE2 = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // 16-bit frame, MSB first: player 1 buttons, two idle-high bits, player 2 buttons, two idle-high bits
  function automatic logic [15:0] build_frame(input logic [5:0] j1, input logic [5:0] j2);
    return {j1[BTN_UP], j1[BTN_DOWN], j1[BTN_LEFT], j1[BTN_RIGHT], j1[BTN_FIRE1], j1[BTN_FIRE2],
            2'b11,
            j2[BTN_UP], j2[BTN_DOWN], j2[BTN_LEFT], j2[BTN_RIGHT], j2[BTN_FIRE1], j2[BTN_FIRE2],
            2'b11};
  endfunction

endpackage

// File: rtl/sync_edge.sv
// N-stage synchronizer for an asynchronous input, followed by one history flop
// that turns the synchronized level into single-cycle rise/fall pulses.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] stage;
  logic              prev;

  // Shift the raw input through the synchronizer and remember the last synchronized level
  always_ff @(posedge clk) begin
    if (reset) begin
      stage <= '1;
      prev  <= 1'b1;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < STAGES; i++) begin
        stage[i] <= stage[i-1];
      end
      prev <= stage[STAGES-1];
    end
  end

  assign sync = stage[STAGES-1];
  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/joy_serializer.sv
// Joystick parallel-in/serial-out frame generator emulating a 74HC165 chain,
// driven by an asynchronous host shift clock and active-low load strobe.
module joy_serializer
  import joy_pkg::*;
#(
  parameter int FRAME_BITS   = FRAME_BITS_DEFAULT,
  parameter int SYNC_STAGES  = 2,
  parameter int IDLE_TIMEOUT = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       joy_clk_i,
  input  logic       joy_load_i,
  input  logic [5:0] joy1_i,
  input  logic [5:0] joy2_i,
  output logic       joy_data_o,
  output logic       frame_done_o,
  output logic       link_active_o
);

  localparam int              BCW       = $clog2(FRAME_BITS + 1);
  localparam int              ICW       = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [BCW-1:0]  BIT_LAST  = BCW'(FRAME_BITS - 1);
  localparam logic [ICW-1:0]  IDLE_INIT = ICW'(IDLE_TIMEOUT);
  localparam logic [ICW-1:0]  IDLE_ONE  = ICW'(1);

  state_t                state;
  logic [FRAME_BITS-1:0] shreg;
  logic [FRAME_BITS-1:0] image;
  logic [15:0]           frame16;
  logic [BCW-1:0]        bit_cnt;
  logic [ICW-1:0]        idle_cnt;
  logic                  frame_done;
  logic                  link;

  logic ck_rise, ck_level_unused, ck_fall_unused;
  logic ld_level, ld_rise, ld_fall;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_clk (
    .clk   (clk),
    .reset (reset),
    .din   (joy_clk_i),
    .sync  (ck_level_unused),
    .rise  (ck_rise),
    .fall  (ck_fall_unused)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_load (
    .clk   (clk),
    .reset (reset),
    .din   (joy_load_i),
    .sync  (ld_level),
    .rise  (ld_rise),
    .fall  (ld_fall)
  );

  // Parallel image: 16-bit button frame in the MSBs, any extra low bits idle high
  always_comb begin
    frame16 = build_frame(joy1_i, joy2_i);
    image   = '1;
    for (int i = 0; i < 16 && i < FRAME_BITS; i++) begin
      image[FRAME_BITS-1-i] = frame16[15-i];
    end
  end

  // Frame FSM, shift register, bit counter and link-idle watchdog
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      shreg      <= '1;
      bit_cnt    <= '0;
      idle_cnt   <= '0;
      frame_done <= 1'b0;
      link       <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (ld_fall) begin
        // A new load always wins: aborts any frame in progress and rearms the watchdog
        state    <= ST_LOAD;
        shreg    <= image;
        idle_cnt <= IDLE_INIT;
        link     <= 1'b1;
      end else if (idle_cnt == IDLE_ONE) begin
        // Host went quiet: drop the link and park the line high
        idle_cnt <= '0;
        link     <= 1'b0;
        state    <= ST_IDLE;
        shreg    <= '1;
        bit_cnt  <= '0;
      end else begin
        if (idle_cnt != '0) begin
          idle_cnt <= idle_cnt - 1'b1;
        end
        case (state)
          ST_LOAD: begin
            if (ld_rise) begin
              state   <= ST_SHIFT;
              bit_cnt <= '0;
            end else begin
              shreg <= image;
            end
          end
          ST_SHIFT: begin
            if (ck_rise && ld_level) begin
              shreg   <= {shreg[FRAME_BITS-2:0], 1'b1};
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == BIT_LAST) begin
                state      <= ST_DONE;
                frame_done <= 1'b1;
              end
            end
          end
          ST_DONE: begin
            if (ck_rise && ld_level) begin
              shreg <= {shreg[FRAME_BITS-2:0], 1'b1};
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign joy_data_o    = shreg[FRAME_BITS-1];
  assign frame_done_o  = frame_done;
  assign link_active_o = link;

endmodule
